// File: rtl/alu_seq_if.sv
// Request, ALU and completion signals shared between the sequencer and its environment.
interface alu_seq_if;
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 4;

    logic          req;
    logic          abort;
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_res;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [1:0]    err;

    modport master (
        output req, abort, op, a, b, alu_res,
        input  alu_a, alu_b, alu_op, busy, done, result, err
    );

    modport slave (
        input  req, abort, op, a, b, alu_res,
        output alu_a, alu_b, alu_op, busy, done, result, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: latches operands, waits ALU_LAT edges,
// captures the result with error classification, and strobes done for one cycle.
module alu_sequencer #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 4;

    localparam logic [OW-1:0] OP_PLUS  = 4'b1100;
    localparam logic [OW-1:0] OP_MINUS = 4'b1101;
    localparam logic [OW-1:0] OP_DIV   = 4'b1111;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_ILL  = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [OW-1:0] op_q, op_d;
    logic [DW-1:0] result_q, result_d;
    logic [1:0]    err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= ERR_OK;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                // abort has priority over a simultaneous request
                if (bus.req && !bus.abort) begin
                    a_d  = bus.a;
                    b_d  = bus.b;
                    op_d = bus.op;
                    if (bus.op < OP_PLUS) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        err_d    = ERR_ILL;
                    end else if (bus.op == OP_DIV && bus.b == '0) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        err_d    = ERR_DIV0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(ALU_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d  = S_DONE;
                    result_d = bus.alu_res;
                    if (op_q == OP_PLUS && bus.alu_res < a_q) begin
                        err_d = ERR_OVF;
                    end else if (op_q == OP_MINUS && b_q > a_q) begin
                        err_d = ERR_OVF;
                    end else begin
                        err_d = ERR_OK;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;
    assign bus.alu_op = op_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a behavioural ALU stand-in.
module tb_alu_sequencer;
    localparam int unsigned ALU_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    alu_seq_if bus ();

    alu_sequencer #(.ALU_LAT(ALU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU stand-in
    always_comb begin
        bus.alu_res = '0;
        case (bus.alu_op)
            4'hC: bus.alu_res = bus.alu_a + bus.alu_b;
            4'hD: bus.alu_res = bus.alu_a - bus.alu_b;
            4'hE: bus.alu_res = 16'(bus.alu_a * bus.alu_b);
            4'hF: bus.alu_res = (bus.alu_b == '0) ? 16'h0000 : bus.alu_a / bus.alu_b;
            default: bus.alu_res = '0;
        endcase
    end

    typedef struct {
        logic [15:0] res;
        logic [1:0]  err;
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_res = '0;
    logic [1:0]  last_err = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the operation rules, using plain integer arithmetic
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic [1:0] err, output logic fast);
        int unsigned ua = a;
        int unsigned ub = b;
        fast = 1'b0;
        err  = 2'd0;
        res  = '0;
        if (op < 4'd12) begin
            fast = 1'b1;
            err  = 2'd2;
        end else if (op == 4'd15 && b == 16'd0) begin
            fast = 1'b1;
            err  = 2'd1;
        end else begin
            case (op)
                4'd12: begin
                    res = 16'(ua + ub);
                    if (ua + ub > 32'd65535) err = 2'd3;
                end
                4'd13: begin
                    res = 16'(ua - ub);
                    if (ub > ua) err = 2'd3;
                end
                4'd14: res = 16'(ua * ub);
                default: res = 16'(ua / ub);
            endcase
        end
    endfunction

    task automatic scramble();
        bus.a  = 16'($urandom);
        bus.b  = 16'($urandom);
        bus.op = 4'($urandom);
    endtask

    // Monitor: every done strobe is matched against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done high at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("result", 32'(bus.result), 32'(e.res));
                check("err", 32'(bus.err), 32'(e.err));
                check("busy_in_done", 32'(bus.busy), 32'd1);
                check("alu_a_held", 32'(bus.alu_a), 32'(e.a));
                check("alu_b_held", 32'(bus.alu_b), 32'(e.b));
                check("alu_op_held", 32'(bus.alu_op), 32'(e.op));
            end
        end
    end

    // mode 0: plain, 1: abort at first WAIT edge, 2: abort during done, 3: keep req high
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int mode_in);
        logic [15:0] res;
        logic [1:0]  err;
        logic        fast;
        int          e0;
        int          ecyc;
        int          mode;
        exp_t        e;
        mode = mode_in;
        model(op, a, b, res, err, fast);
        if (mode == 1 && (fast || ALU_LAT < 2)) mode = 0;
        bus.req   = 1'b1;
        bus.abort = 1'b0;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e0   = cyc + 1;
        ecyc = e0 + (fast ? 0 : int'(ALU_LAT));
        if (mode != 1) begin
            e.res = res; e.err = err; e.cyc = ecyc; e.a = a; e.b = b; e.op = op;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.req   = (mode == 3);
        bus.abort = (mode == 1);
        scramble();
        if (mode == 1) begin
            @(negedge clk);
            bus.abort = 1'b0;
            check("abort_idle", 32'(bus.busy), 32'd0);
            check("abort_result_kept", 32'(bus.result), 32'(last_res));
            check("abort_err_kept", 32'(bus.err), 32'(last_err));
            return;
        end
        while (cyc < ecyc) begin
            if (mode != 3) bus.req = 1'($urandom_range(0, 1));
            scramble();
            @(negedge clk);
        end
        if (mode == 2) bus.abort = 1'b1;
        bus.req = (mode == 3);
        @(negedge clk);
        bus.abort = 1'b0;
        if (mode != 3) bus.req = 1'b0;
        check("idle_after_done", 32'(bus.busy), 32'd0);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        last_res = res;
        last_err = err;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.abort = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        do_op(4'hC, 16'h0012, 16'h0034, 0);
        do_op(4'hF, 16'h0064, 16'h0000, 0);
        do_op(4'hC, 16'hFFFF, 16'h0002, 0);
        do_op(4'hD, 16'h0003, 16'h0005, 0);
        do_op(4'hA, 16'h1111, 16'h2222, 0);
        do_op(4'hE, 16'h1234, 16'h0100, 1);
        do_op(4'hE, 16'h0300, 16'h0101, 2);
        do_op(4'hF, 16'h9000, 16'h0007, 0);
        do_op(4'hC, 16'h0001, 16'h0002, 3);
        do_op(4'hD, 16'h000A, 16'h0004, 0);

        // abort together with req in IDLE must not start anything
        bus.req = 1'b1; bus.abort = 1'b1; bus.op = 4'hC; bus.a = 16'h0005; bus.b = 16'h0006;
        @(negedge clk);
        bus.req = 1'b0; bus.abort = 1'b0;
        check("abort_req_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("abort_req_idle_later", 32'(bus.busy), 32'd0);
        check("abort_req_result_kept", 32'(bus.result), 32'(last_res));

        // asynchronous reset in the middle of WAIT
        bus.req = 1'b1; bus.op = 4'hD; bus.a = 16'h0050; bus.b = 16'h0010;
        @(negedge clk);
        bus.req = 1'b0;
        check("busy_in_wait", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_cleared("async_rst");
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        last_err = '0;
        do_op(4'hC, 16'h0100, 16'h0200, 0);

        repeat (60) begin
            rop = ($urandom_range(0, 9) < 7) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 11));
            ra  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            do_op(rop, ra, rb, int'($urandom_range(0, 3)));
        end
        do_op(4'hE, 16'h00FF, 16'h0101, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
